// File: rtl/cache_line.sv
// Single cache line (tag, valid, dirty, LRU age, byte block) used as one way of a set.
// Optional define CACHE_LINE_AGE_SATURATE_EN makes the age counter saturate at 3 instead of wrapping.
module cache_line #(
  parameter int ADDRESS_WORD_SIZE = 32,
  parameter int TAG_SIZE          = 19,
  parameter int BLOCK_SIZE        = 16,
  parameter int WORD_SIZE         = 4
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         ready,
  input  logic [ADDRESS_WORD_SIZE-1:0] address_word,
  input  logic                         try_read,
  input  logic                         try_write,
  input  logic [7:0]                   write_data,
  input  logic                         reset_age,
  input  logic                         increment_age,
  output logic [7:0]                   data,
  output logic [1:0]                   age,
  output logic                         hit_miss,
  output logic                         is_empty,
  output logic                         valid,
  output logic                         dirty
);

  localparam int OFFSET_W = $clog2(BLOCK_SIZE);
  localparam int MID_W    = ADDRESS_WORD_SIZE - TAG_SIZE - OFFSET_W;

  logic [TAG_SIZE-1:0] tag_q;
  logic [7:0]          block_q [BLOCK_SIZE];
  logic                valid_q;
  logic                dirty_q;
  logic [1:0]          age_q;
  logic [7:0]          data_q;
  logic                hit_miss_q;

  logic [TAG_SIZE-1:0] addr_tag;
  logic [OFFSET_W-1:0] offset;
  logic                access;
  logic                is_write;
  logic                hit;

  assign addr_tag = address_word[ADDRESS_WORD_SIZE-1 -: TAG_SIZE];
  assign offset   = address_word[OFFSET_W-1:0];
  assign access   = ready && (try_read || try_write);
  assign is_write = try_write;
  assign hit      = valid_q && (tag_q == addr_tag);

  // Index bits between tag and offset select the set outside this block.
  generate
    if (MID_W > 0) begin : g_mid
      logic unused_index;
      assign unused_index = ^address_word[ADDRESS_WORD_SIZE-TAG_SIZE-1:OFFSET_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      tag_q      <= '0;
      valid_q    <= 1'b0;
      dirty_q    <= 1'b0;
      data_q     <= '0;
      hit_miss_q <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) block_q[i] <= '0;
    end else if (access) begin
      hit_miss_q <= hit;
      if (is_write) begin
        data_q  <= write_data;
        dirty_q <= 1'b1;
        if (hit) begin
          block_q[offset] <= write_data;
        end else begin
          // Miss overwrites unconditionally; the controller handles any write-back first.
          tag_q   <= addr_tag;
          valid_q <= 1'b1;
          for (int i = 0; i < BLOCK_SIZE; i++)
            block_q[i] <= (i == int'(offset)) ? write_data : 8'h00;
        end
      end else begin
        if (hit) begin
          data_q <= block_q[offset];
        end else begin
          tag_q   <= addr_tag;
          valid_q <= 1'b1;
          dirty_q <= 1'b0;
          data_q  <= 8'h00;
          for (int i = 0; i < BLOCK_SIZE; i++) block_q[i] <= 8'h00;
        end
      end
    end
  end

  // Access outranks reset_age, which outranks increment_age.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      age_q <= 2'd0;
    end else if (access || reset_age) begin
      age_q <= 2'd0;
    end else if (increment_age) begin
`ifdef CACHE_LINE_AGE_SATURATE_EN
      if (age_q != 2'd3) age_q <= age_q + 2'd1;
`else
      age_q <= age_q + 2'd1;
`endif
    end
  end

  assign data     = data_q;
  assign age      = age_q;
  assign hit_miss = hit_miss_q;
  assign valid    = valid_q;
  assign dirty    = dirty_q;
  assign is_empty = ~valid_q;

endmodule

// File: tb/tb_cache_line.sv
// Directed self-checking bench for cache_line: lookups, allocation, age counter and async reset.
module tb_cache_line;

  logic        clk;
  logic        rst_b;
  logic        ready;
  logic [31:0] address_word;
  logic        try_read;
  logic        try_write;
  logic [7:0]  write_data;
  logic        reset_age;
  logic        increment_age;
  logic [7:0]  data;
  logic [1:0]  age;
  logic        hit_miss;
  logic        is_empty;
  logic        valid;
  logic        dirty;

  int tests_run = 0;
  int tests_failed = 0;

  cache_line dut (
    .clk(clk), .rst_b(rst_b), .ready(ready), .address_word(address_word),
    .try_read(try_read), .try_write(try_write), .write_data(write_data),
    .reset_age(reset_age), .increment_age(increment_age),
    .data(data), .age(age), .hit_miss(hit_miss), .is_empty(is_empty),
    .valid(valid), .dirty(dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic e_empty, input logic e_valid,
                             input logic e_dirty, input logic e_hit, input logic [1:0] e_age,
                             input logic [7:0] e_data);
    check({tag, ".is_empty"}, {7'd0, is_empty}, {7'd0, e_empty});
    check({tag, ".valid"},    {7'd0, valid},    {7'd0, e_valid});
    check({tag, ".dirty"},    {7'd0, dirty},    {7'd0, e_dirty});
    check({tag, ".hit_miss"}, {7'd0, hit_miss}, {7'd0, e_hit});
    check({tag, ".age"},      {6'd0, age},      {6'd0, e_age});
    check({tag, ".data"},     data,             e_data);
  endtask

  task automatic idle();
    ready = 1'b0; try_read = 1'b0; try_write = 1'b0;
    reset_age = 1'b0; increment_age = 1'b0; write_data = 8'h00;
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    @(negedge clk);
    idle();
  endtask

  task automatic do_read(input logic [31:0] a);
    ready = 1'b1; try_read = 1'b1; address_word = a;
    step();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] d);
    ready = 1'b1; try_write = 1'b1; address_word = a; write_data = d;
    step();
  endtask

  task automatic pulse_inc();
    increment_age = 1'b1;
    step();
  endtask

  initial begin
    logic [1:0] age_after_four;
    idle();
    address_word = 32'h0;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check_state("reset", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

    do_read(32'hA5A5_1234);
    check_state("rd_miss", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);

    do_read(32'hA5A5_1234);
    check_state("rd_hit", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);

    do_write(32'hDEAD_BEEF, 8'h5A);
    check_state("wr_miss", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h5A);

    do_write(32'hDEAD_BEEF, 8'hA5);
    check_state("wr_hit", 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 8'hA5);

    do_read(32'hDEAD_BEEF);
    check_state("rd_after_wr", 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 8'hA5);

    // Other bytes of the allocated block were cleared by the write miss.
    do_read(32'hDEAD_BEE0);
    check("rd_other_byte.data", data, 8'h00);
    check("rd_other_byte.hit", {7'd0, hit_miss}, 8'h01);

    // Write wins over read when both are requested.
    ready = 1'b1; try_read = 1'b1; try_write = 1'b1;
    address_word = 32'hDEAD_BEE0; write_data = 8'h3C;
    step();
    check("rw_prio.data", data, 8'h3C);
    do_read(32'hDEAD_BEE0);
    check("rw_prio_readback.data", data, 8'h3C);
    do_read(32'hDEAD_BEEF);
    check("byte_f_kept.data", data, 8'hA5);

    // Age counter sequence.
    reset_age = 1'b1;
    step();
    check("age_reset", {6'd0, age}, 8'd0);
    pulse_inc(); check("age_inc1", {6'd0, age}, 8'd1);
    pulse_inc(); check("age_inc2", {6'd0, age}, 8'd2);
    pulse_inc(); check("age_inc3", {6'd0, age}, 8'd3);
    pulse_inc();
`ifdef CACHE_LINE_AGE_SATURATE_EN
    age_after_four = 2'd3;
`else
    age_after_four = 2'd0;
`endif
    check("age_inc4", {6'd0, age}, {6'd0, age_after_four});

    // ready=0 ignores the request entirely, including the age clear.
    reset_age = 1'b1; step();
    pulse_inc();
    ready = 1'b0; try_read = 1'b1; try_write = 1'b1;
    address_word = 32'h1234_5678; write_data = 8'hEE;
    step();
    check_state("not_ready", 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'hA5);

    // An access clears age.
    do_read(32'h1234_5678);
    check_state("alloc_clears_age", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);

    // reset_age outranks increment_age.
    pulse_inc(); pulse_inc();
    check("age_at_2", {6'd0, age}, 8'd2);
    reset_age = 1'b1; increment_age = 1'b1;
    step();
    check("age_both", {6'd0, age}, 8'd0);

    // Asynchronous reset mid-cycle, checked before any rising edge.
    do_write(32'h1234_5671, 8'h77);
    pulse_inc();
    @(negedge clk);
    #2;
    rst_b = 1'b1;
    #1;
    check_state("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    rst_b = 1'b0;
    do_read(32'h1234_5671);
    check_state("post_rst_miss", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_line.md
Name: cache_line

Overview:
- Single cache line (tag, valid, dirty, 2-bit age, BLOCK_SIZE-byte data block) used as one way of a set-associative cache controller.
- Performs byte-granular read/write lookups against its stored tag and allocates itself on a miss.
- Exposes hit/miss, state bits and an LRU age counter to the surrounding set/replacement logic.

Parameters:
- ADDRESS_WORD_SIZE, 32: address width in bits.
- TAG_SIZE, 19: tag width; tag = address_word[ADDRESS_WORD_SIZE-1 -: TAG_SIZE].
- BLOCK_SIZE, 16: bytes per block (power of two); byte offset = address_word[log2(BLOCK_SIZE)-1:0].
- WORD_SIZE, 4: bytes per word; informational only (offset is byte-granular); must divide BLOCK_SIZE.

Ports:
- clk, input, 1: clock, rising edge.
- rst_b, input, 1: reset, asynchronous, active-high.
- ready, input, 1: access qualifier; try_read/try_write are ignored when 0.
- address_word, input, ADDRESS_WORD_SIZE: access address.
- try_read, input, 1: read request.
- try_write, input, 1: write request.
- write_data, input, 8: byte to write.
- reset_age, input, 1: clear age to 0.
- increment_age, input, 1: age +1.
- data, output, 8: registered byte from the last access.
- age, output, 2: LRU age.
- hit_miss, output, 1: registered; 1 = last access hit, 0 = miss.
- is_empty, output, 1: equals ~valid.
- valid, output, 1: line holds an allocated tag.
- dirty, output, 1: line modified since allocation.

Behaviour:
- Reset (rst_b=1, asynchronous): valid=0, dirty=0, stored tag=0, all block bytes=0, data=0, age=0, hit_miss=0, is_empty=1.
- Access: ready=1 and (try_read or try_write), sampled on the rising clk edge. All results are visible 1 cycle later.
- Write has priority when try_read and try_write are both 1.
- hit = valid and (stored tag == address tag), evaluated combinationally against the pre-edge state.
- Read hit: data <= block[offset]; hit_miss <= 1; tag, valid and dirty unchanged.
- Read miss (allocate): tag <= address tag; valid <= 1; dirty <= 0; all bytes <= 0; data <= 0; hit_miss <= 0.
- Write hit: block[offset] <= write_data; data <= write_data; dirty <= 1; hit_miss <= 1.
- Write miss (allocate): tag <= address tag; valid <= 1; dirty <= 1; all bytes <= 0 except block[offset] <= write_data; data <= write_data; hit_miss <= 0.
- No write-back path in this block. The controller reads dirty before issuing a replacing access; a miss overwrites the line unconditionally.
- Any access (hit or miss) sets age <= 0.
- Age priority, highest first: access, reset_age, increment_age. Age updates regardless of valid.
- increment_age at age=3: behaviour set by the optional feature below.
- With no access, data and hit_miss hold their values; ready=0 with try_* high has no effect.
- Reset mid-operation: reset overrides immediately; the access in flight is lost.

Optional Feature:
- CACHE_LINE_AGE_SATURATE_EN.
- Defined: increment_age at age=3 keeps age=3 (saturating).
- Undefined: age wraps modulo 4 (3 -> 0).

Test Plan:
- Reset for 2 cycles, then release -> is_empty=1, valid=0, dirty=0, hit_miss=0, age=0, data=00.
- Read 0xA5A51234 with ready=1 for 1 cycle -> is_empty=0, valid=1, dirty=0, hit_miss=0, age=0, data=00.
- Read 0xA5A51234 again -> hit_miss=1, dirty=0, data=00.
- Write 0x5A to 0xDEADBEEF (different tag) -> hit_miss=0, valid=1, dirty=1, data=5A. Then write 0xA5 to the same address -> hit_miss=1, dirty=1, data=A5. Then read 0xDEADBEEF -> hit_miss=1, data=A5.
- Pulse reset_age -> age=0. Three single-cycle increment_age pulses -> age 1, 2, 3. A fourth pulse -> age=3 with CACHE_LINE_AGE_SATURATE_EN defined, 0 without.
- try_read=1 with ready=0 -> no state change. Assert reset_age and increment_age together at age=2 -> age=0. Assert rst_b mid-cycle -> outputs return to reset values without waiting for a clk edge.
